// File: rtl/gshare_branch_predictor_if.sv
// Fetch <-> branch predictor interface.
// The fetch stage (master) supplies its PC latch and the AGEX resolution
// fields. The predictor (slave) answers with the next fetch PC, a flush
// request, the global history and the statistics counters.
interface gshare_branch_predictor_if #(
    parameter int DBITS    = 32,
    parameter int BHR_BITS = 8
);
    logic [DBITS-1:0]    fe_pc;
    logic                res_valid;
    logic                res_taken;
    logic [DBITS-1:0]    res_pc;
    logic [DBITS-1:0]    res_target;
    logic [DBITS-1:0]    res_pred_pc;
    logic [BHR_BITS-1:0] res_bhr;
    logic                flush;
    logic [DBITS-1:0]    pred_pc;
    logic [BHR_BITS-1:0] bhr_out;
    logic [31:0]         stat_branches;
    logic [31:0]         stat_mispred;

    modport master (
        output fe_pc, res_valid, res_taken, res_pc, res_target, res_pred_pc, res_bhr,
        input  flush, pred_pc, bhr_out, stat_branches, stat_mispred
    );

    modport slave (
        input  fe_pc, res_valid, res_taken, res_pc, res_target, res_pred_pc, res_bhr,
        output flush, pred_pc, bhr_out, stat_branches, stat_mispred
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// gshare branch predictor with a direct-mapped BTB.
// Prediction is combinational from the fetch PC. Tables, the global history
// and the statistics are trained at the clock edge from AGEX resolutions.
// The history is non-speculative: it only advances on resolution, and the
// value a branch was predicted with travels down the pipe as res_bhr.
module gshare_branch_predictor #(
    parameter int DBITS        = 32,
    parameter int BHR_BITS     = 8,
    parameter int BTB_IDX_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    gshare_branch_predictor_if.slave bp
);

    localparam int PHT_ENTRIES = 1 << BHR_BITS;
    localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int TAG_BITS    = DBITS - BTB_IDX_BITS - 2;
    localparam logic [DBITS-1:0] PC_STEP = DBITS'(3'd4);

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

    // Architectural state.
    logic [1:0]              pht_q        [PHT_ENTRIES];
    logic [1:0]              pht_d        [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0]  btb_valid_q;
    logic [BTB_ENTRIES-1:0]  btb_valid_d;
    logic [TAG_BITS-1:0]     btb_tag_q    [BTB_ENTRIES];
    logic [TAG_BITS-1:0]     btb_tag_d    [BTB_ENTRIES];
    logic [DBITS-1:0]        btb_target_q [BTB_ENTRIES];
    logic [DBITS-1:0]        btb_target_d [BTB_ENTRIES];
    logic [BHR_BITS-1:0]     bhr_q;
    logic [BHR_BITS-1:0]     bhr_d;
    logic [31:0]             stat_branches_q;
    logic [31:0]             stat_branches_d;
    logic [31:0]             stat_mispred_q;
    logic [31:0]             stat_mispred_d;

    // Fetch-side lookup.
    logic [BHR_BITS-1:0]     pht_idx_s;
    logic [BTB_IDX_BITS-1:0] btb_idx_s;
    logic [TAG_BITS-1:0]     btb_tag_s;
    logic                    btb_hit_s;
    logic                    pred_taken_s;
    logic [DBITS-1:0]        fetch_next_s;

    // Resolution side.
    logic [DBITS-1:0]        actual_next_s;
    logic                    flush_s;
    logic [BHR_BITS-1:0]     train_pht_idx_s;
    logic [BTB_IDX_BITS-1:0] train_btb_idx_s;
    logic [TAG_BITS-1:0]     train_tag_s;

    // PC bits [1:0] never participate in indexing (word-aligned fetch).
    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{bp.fe_pc[1:0], bp.res_pc[1:0]};

    // Fetch prediction: BTB hit with a taken-leaning counter redirects to the stored target.
    always_comb begin
        pht_idx_s    = bp.fe_pc[BHR_BITS+1:2] ^ bhr_q;
        btb_idx_s    = bp.fe_pc[BTB_IDX_BITS+1:2];
        btb_tag_s    = bp.fe_pc[DBITS-1:BTB_IDX_BITS+2];
        btb_hit_s    = btb_valid_q[btb_idx_s] && (btb_tag_q[btb_idx_s] == btb_tag_s);
        pred_taken_s = btb_hit_s && (pht_q[pht_idx_s] >= 2'b10);
        if (pred_taken_s) begin
            fetch_next_s = btb_target_q[btb_idx_s];
        end else begin
            fetch_next_s = bp.fe_pc + PC_STEP;
        end
    end

    // Mispredict detection: compare the real next PC with what was predicted for the branch.
    always_comb begin
        if (bp.res_taken) begin
            actual_next_s = bp.res_target;
        end else begin
            actual_next_s = bp.res_pc + PC_STEP;
        end
        flush_s = bp.res_valid && (actual_next_s != bp.res_pred_pc);
    end

    // Outputs: a flush redirect always overrides the fetch prediction.
    always_comb begin
        bp.flush         = flush_s;
        bp.bhr_out       = bhr_q;
        bp.stat_branches = stat_branches_q;
        bp.stat_mispred  = stat_mispred_q;
        if (flush_s) begin
            bp.pred_pc = actual_next_s;
        end else begin
            bp.pred_pc = fetch_next_s;
        end
    end

    // Training next-state: PHT counter, BTB fill on taken, history shift and statistics.
    always_comb begin
        train_pht_idx_s = bp.res_pc[BHR_BITS+1:2] ^ bp.res_bhr;
        train_btb_idx_s = bp.res_pc[BTB_IDX_BITS+1:2];
        train_tag_s     = bp.res_pc[DBITS-1:BTB_IDX_BITS+2];
        pht_d           = pht_q;
        btb_valid_d     = btb_valid_q;
        btb_tag_d       = btb_tag_q;
        btb_target_d    = btb_target_q;
        bhr_d           = bhr_q;
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (bp.res_valid) begin
            pht_d[train_pht_idx_s] = sat_update(pht_q[train_pht_idx_s], bp.res_taken);
            if (bp.res_taken) begin
                btb_valid_d[train_btb_idx_s]  = 1'b1;
                btb_tag_d[train_btb_idx_s]    = train_tag_s;
                btb_target_d[train_btb_idx_s] = bp.res_target;
            end else begin
                btb_valid_d = btb_valid_q;
            end
            bhr_d           = {bhr_q[BHR_BITS-2:0], bp.res_taken};
            stat_branches_d = stat_branches_q + 32'd1;
            if (flush_s) begin
                stat_mispred_d = stat_mispred_q + 32'd1;
            end else begin
                stat_mispred_d = stat_mispred_q;
            end
        end else begin
            bhr_d = bhr_q;
        end
    end

    // State registers; synchronous reset takes priority over any same-cycle training.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_q[i]    <= {TAG_BITS{1'b0}};
                btb_target_q[i] <= {DBITS{1'b0}};
            end
            btb_valid_q     <= {BTB_ENTRIES{1'b0}};
            bhr_q           <= {BHR_BITS{1'b0}};
            stat_branches_q <= 32'd0;
            stat_mispred_q  <= 32'd0;
        end else begin
            pht_q           <= pht_d;
            btb_valid_q     <= btb_valid_d;
            btb_tag_q       <= btb_tag_d;
            btb_target_q    <= btb_target_d;
            bhr_q           <= bhr_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed testbench for gshare_branch_predictor. Each step drives one cycle
// of fetch/resolution inputs, queues the expected outputs, and compares them
// half a cycle later. Expected statistics are accumulated by the bench.
module tb_gshare_branch_predictor;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gshare_branch_predictor_if #(.DBITS(32), .BHR_BITS(8)) bp_if ();

    gshare_branch_predictor #(
        .DBITS(32),
        .BHR_BITS(8),
        .BTB_IDX_BITS(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bp   (bp_if.slave)
    );

    typedef struct {
        string       tag;
        logic        flush;
        logic [31:0] pc;
        logic [7:0]  bhr;
        logic [31:0] br;
        logic [31:0] mis;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_br = 32'd0;
    logic [31:0] exp_mis = 32'd0;

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s: observed 0x%08h expected 0x%08h", tag, field, obs, expv);
        end
    endtask

    task automatic drive(input logic [31:0] fe, input logic v, input logic t,
                         input logic [31:0] rpc, input logic [31:0] tgt,
                         input logic [31:0] ppc, input logic [7:0] rbhr);
        bp_if.fe_pc       = fe;
        bp_if.res_valid   = v;
        bp_if.res_taken   = t;
        bp_if.res_pc      = rpc;
        bp_if.res_target  = tgt;
        bp_if.res_pred_pc = ppc;
        bp_if.res_bhr     = rbhr;
    endtask

    // One cycle: drive, queue expectation, compare at the falling edge, then clock.
    task automatic step(input string tag, input logic [31:0] fe, input logic v,
                        input logic t, input logic [31:0] rpc, input logic [31:0] tgt,
                        input logic [31:0] ppc, input logic [7:0] rbhr,
                        input logic ef, input logic [31:0] epc, input logic [7:0] ebhr);
        exp_t e;
        drive(fe, v, t, rpc, tgt, ppc, rbhr);
        e.tag = tag; e.flush = ef; e.pc = epc; e.bhr = ebhr;
        e.br = exp_br; e.mis = exp_mis;
        sb_q.push_back(e);
        #4;
        if (sb_q.size() == 0) begin
            cmp(tag, "scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            cmp(e.tag, "flush",    {31'd0, bp_if.flush},   {31'd0, e.flush});
            cmp(e.tag, "pred_pc",  bp_if.pred_pc,          e.pc);
            cmp(e.tag, "bhr_out",  {24'd0, bp_if.bhr_out}, {24'd0, e.bhr});
            cmp(e.tag, "branches", bp_if.stat_branches,    e.br);
            cmp(e.tag, "mispred",  bp_if.stat_mispred,     e.mis);
        end
        @(posedge clk);
        #1;
        if (v) begin
            exp_br = exp_br + 32'd1;
            if (ef) exp_mis = exp_mis + 32'd1;
        end
    endtask

    task automatic idle(input string tag, input logic [31:0] fe,
                        input logic [31:0] epc, input logic [7:0] ebhr);
        step(tag, fe, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0, epc, ebhr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        idle("reset", 32'h100, 32'h104, 8'h00);
        idle("pc_wrap", 32'hFFFF_FFFC, 32'h0000_0000, 8'h00);

        // Cold taken branch: mispredicted, redirect to target.
        step("cold_taken", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 8'h00, 1'b1, 32'h200, 8'h00);
        // History is now 0x01: index 0x41 still weakly not-taken.
        idle("untrained_idx", 32'h100, 32'h104, 8'h01);

        // Train index 0x47, which is the index fetch of 0x100 uses once history reaches 0x07.
        step("train1", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 8'h07, 1'b1, 32'h200, 8'h01);
        step("train2", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 8'h07, 1'b1, 32'h200, 8'h03);
        idle("trained_hit", 32'h100, 32'h200, 8'h07);
        idle("stall_hold", 32'h100, 32'h200, 8'h07);

        // Correctly predicted taken branch: no flush, fetch prediction stands.
        step("correct_pred", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h200, 8'h07, 1'b0, 32'h200, 8'h07);
        idle("after_correct", 32'h100, 32'h104, 8'h0F);

        // Low saturation on index 0xA1 (observed later with history 0xE1).
        step("nt1", 32'h100, 1'b1, 1'b0, 32'h100, 32'h200, 32'h104, 8'hE1, 1'b0, 32'h104, 8'h0F);
        step("nt2", 32'h100, 1'b1, 1'b0, 32'h100, 32'h200, 32'h104, 8'hE1, 1'b0, 32'h104, 8'h1E);
        step("nt3", 32'h100, 1'b1, 1'b0, 32'h100, 32'h200, 32'h104, 8'hE1, 1'b0, 32'h104, 8'h3C);
        step("nt4", 32'h100, 1'b1, 1'b0, 32'h100, 32'h200, 32'h104, 8'hE1, 1'b0, 32'h104, 8'h78);
        step("nt_recover", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 8'hE1, 1'b1, 32'h200, 8'hF0);
        // Counter 00 -> 01 after one taken: still not-taken.
        idle("sat_low_obs", 32'h100, 32'h104, 8'hE1);

        // High saturation on index 0x3E (observed with history 0x7E).
        step("tk1", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 8'h7E, 1'b1, 32'h200, 8'hE1);
        step("tk2", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 8'h7E, 1'b1, 32'h200, 8'hC3);
        step("tk3", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 8'h7E, 1'b1, 32'h200, 8'h87);
        step("tk4", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 8'h7E, 1'b1, 32'h200, 8'h0F);
        step("tk5", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104, 8'h7E, 1'b1, 32'h200, 8'h1F);
        step("tk_back", 32'h100, 1'b1, 1'b0, 32'h100, 32'h200, 32'h104, 8'h7E, 1'b0, 32'h104, 8'h3F);
        // Counter 11 -> 10 after one not-taken: still taken, BTB entry still valid.
        idle("sat_high_obs", 32'h100, 32'h200, 8'h7E);

        // BTB alias: 0x140 shares entry 0 with 0x100 but has a different tag.
        step("alias1", 32'h100, 1'b1, 1'b1, 32'h140, 32'h300, 32'h144, 8'hF7, 1'b1, 32'h300, 8'h7E);
        step("alias2", 32'h100, 1'b1, 1'b1, 32'h140, 32'h300, 32'h144, 8'hF7, 1'b1, 32'h300, 8'hFD);
        step("alias3", 32'h100, 1'b1, 1'b1, 32'h140, 32'h300, 32'h144, 8'hF7, 1'b1, 32'h300, 8'hFB);
        idle("alias_hit", 32'h140, 32'h300, 8'hF7);
        idle("alias_miss", 32'h100, 32'h104, 8'hF7);

        // Flush and fetch BTB hit in the same cycle: redirect wins.
        step("flush_override", 32'h140, 1'b1, 1'b0, 32'h600, 32'h0, 32'h700, 8'h00, 1'b1, 32'h604, 8'hF7);
        idle("post_flush", 32'h140, 32'h144, 8'hEE);

        // Reset together with a resolution: reset wins, everything cleared.
        reset = 1'b1;
        drive(32'h140, 1'b1, 1'b1, 32'h140, 32'h300, 32'h144, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_br  = 32'd0;
        exp_mis = 32'd0;
        idle("reset_again", 32'h140, 32'h144, 8'h00);
        idle("reset_btb_clear", 32'h100, 32'h104, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
